complete_arbiter: RTL and testbench

Round-robin arbiter that shares the two-wide completion/forwarding bus between the three functional units (FU1–FU3). It accepts result requests under a valid/ready handshake and grants at most two per cycle. Granted results are registered onto two broadcast slots that feed the ROB completion update and the dispatch wakeup/forwarding logic. It replaces the per-FU unconditional completion path, so a third simultaneous result stalls its FU instead of being written in the same pass.

---
 rtl/complete_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_complete_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complete_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : complete_arbiter
// Purpose  : Round-robin arbiter sharing the two-wide completion/forwarding
//            bus between three functional units. Up to two results are
//            granted per cycle and registered onto two broadcast slots.
// Revision : 1.0 - initial release
// ============================================================================
module complete_arbiter #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4,
  parameter int PC_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_1,
  input  logic [DATA_W-1:0] req_result_1,
  input  logic [PREG_W-1:0] req_dest_1,
  input  logic [ROB_W-1:0]  req_rob_1,
  input  logic [PC_W-1:0]   req_pc_1,
  output logic              req_ready_1,
  input  logic              req_valid_2,
  input  logic [DATA_W-1:0] req_result_2,
  input  logic [PREG_W-1:0] req_dest_2,
  input  logic [ROB_W-1:0]  req_rob_2,
  input  logic [PC_W-1:0]   req_pc_2,
  output logic              req_ready_2,
  input  logic              req_valid_3,
  input  logic [DATA_W-1:0] req_result_3,
  input  logic [PREG_W-1:0] req_dest_3,
  input  logic [ROB_W-1:0]  req_rob_3,
  input  logic [PC_W-1:0]   req_pc_3,
  output logic              req_ready_3,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              cdb_valid_0,
  output logic [DATA_W-1:0] cdb_result_0,
  output logic [PREG_W-1:0] cdb_dest_0,
  output logic [ROB_W-1:0]  cdb_rob_0,
  output logic [PC_W-1:0]   cdb_pc_0,
  output logic [1:0]        cdb_fu_0,
  output logic              cdb_valid_1,
  output logic [DATA_W-1:0] cdb_result_1,
  output logic [PREG_W-1:0] cdb_dest_1,
  output logic [ROB_W-1:0]  cdb_rob_1,
  output logic [PC_W-1:0]   cdb_pc_1,
  output logic [1:0]        cdb_fu_1,
  output logic [31:0]       grant_cnt,
  output logic [15:0]       conflict_cnt
);

  // Requester fields gathered into arrays indexed by FU number minus one
  logic [2:0]        valid_w;
  logic [DATA_W-1:0] res_w  [3];
  logic [PREG_W-1:0] dest_w [3];
  logic [ROB_W-1:0]  rob_w  [3];
  logic [PC_W-1:0]   pc_w   [3];

  assign valid_w   = {req_valid_3, req_valid_2, req_valid_1};
  assign res_w[0]  = req_result_1;
  assign res_w[1]  = req_result_2;
  assign res_w[2]  = req_result_3;
  assign dest_w[0] = req_dest_1;
  assign dest_w[1] = req_dest_2;
  assign dest_w[2] = req_dest_3;
  assign rob_w[0]  = req_rob_1;
  assign rob_w[1]  = req_rob_2;
  assign rob_w[2]  = req_rob_3;
  assign pc_w[0]   = req_pc_1;
  assign pc_w[1]   = req_pc_2;
  assign pc_w[2]   = req_pc_3;

  // State: priority pointer, two broadcast slots, two counters
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              valid_q  [2];
  logic              valid_d  [2];
  logic [DATA_W-1:0] res_q    [2];
  logic [DATA_W-1:0] res_d    [2];
  logic [PREG_W-1:0] dest_q   [2];
  logic [PREG_W-1:0] dest_d   [2];
  logic [ROB_W-1:0]  rob_q    [2];
  logic [ROB_W-1:0]  rob_d    [2];
  logic [PC_W-1:0]   pc_q     [2];
  logic [PC_W-1:0]   pc_d     [2];
  logic [1:0]        fu_q     [2];
  logic [1:0]        fu_d     [2];
  logic [31:0]       grant_cnt_q, grant_cnt_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  // Selected FU per slot, encoded 1..3 with 0 meaning no grant
  logic [1:0] sel_w [2];
  logic [1:0] scan_w [3];
  logic       xfer_w;

  // Scan requesters starting at rr_ptr; first two valid ones take slots 0 and 1
  always_comb begin
    sel_w[0]  = 2'd0;
    sel_w[1]  = 2'd0;
    scan_w[0] = rr_ptr_q;
    scan_w[1] = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    scan_w[2] = (scan_w[1] == 2'd2) ? 2'd0 : scan_w[1] + 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (valid_w[scan_w[i]]) begin
        if (sel_w[0] == 2'd0) begin
          sel_w[0] = scan_w[i] + 2'd1;
        end else if (sel_w[1] == 2'd0) begin
          sel_w[1] = scan_w[i] + 2'd1;
        end
      end
    end
  end

  // Ready is suppressed under stall, flush and while reset is held
  assign xfer_w      = !stall_i && !flush_i && rst_n;
  assign req_ready_1 = xfer_w && ((sel_w[0] == 2'd1) || (sel_w[1] == 2'd1));
  assign req_ready_2 = xfer_w && ((sel_w[0] == 2'd2) || (sel_w[1] == 2'd2));
  assign req_ready_3 = xfer_w && ((sel_w[0] == 2'd3) || (sel_w[1] == 2'd3));

  // Next-state: slot loading, pointer rotation and counter updates
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    grant_cnt_d    = grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    for (int s = 0; s < 2; s++) begin
      valid_d[s] = valid_q[s];
      res_d[s]   = res_q[s];
      dest_d[s]  = dest_q[s];
      rob_d[s]   = rob_q[s];
      pc_d[s]    = pc_q[s];
      fu_d[s]    = fu_q[s];
    end
    if (flush_i) begin
      rr_ptr_d = 2'd0;
      for (int s = 0; s < 2; s++) begin
        valid_d[s] = 1'b0;
        fu_d[s]    = 2'd0;
      end
    end else if (stall_i) begin
      for (int s = 0; s < 2; s++) begin
        valid_d[s] = 1'b0;
        fu_d[s]    = 2'd0;
      end
    end else begin
      if ((&valid_w) && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
      grant_cnt_d = grant_cnt_q + {31'd0, sel_w[0] != 2'd0} + {31'd0, sel_w[1] != 2'd0};
      for (int s = 0; s < 2; s++) begin
        if (sel_w[s] != 2'd0) begin
          valid_d[s] = 1'b1;
          fu_d[s]    = sel_w[s];
          res_d[s]   = res_w[sel_w[s] - 2'd1];
          dest_d[s]  = dest_w[sel_w[s] - 2'd1];
          rob_d[s]   = rob_w[sel_w[s] - 2'd1];
          pc_d[s]    = pc_w[sel_w[s] - 2'd1];
        end else begin
          valid_d[s] = 1'b0;
          fu_d[s]    = 2'd0;
        end
      end
      // Priority moves past the last granted FU (FU n -> index n mod 3)
      if (sel_w[1] != 2'd0) begin
        rr_ptr_d = (sel_w[1] == 2'd3) ? 2'd0 : sel_w[1];
      end else if (sel_w[0] != 2'd0) begin
        rr_ptr_d = (sel_w[0] == 2'd3) ? 2'd0 : sel_w[0];
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= 2'd0;
      grant_cnt_q    <= 32'd0;
      conflict_cnt_q <= 16'd0;
      for (int s = 0; s < 2; s++) begin
        valid_q[s] <= 1'b0;
        res_q[s]   <= '0;
        dest_q[s]  <= '0;
        rob_q[s]   <= '0;
        pc_q[s]    <= '0;
        fu_q[s]    <= 2'd0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int s = 0; s < 2; s++) begin
        valid_q[s] <= valid_d[s];
        res_q[s]   <= res_d[s];
        dest_q[s]  <= dest_d[s];
        rob_q[s]   <= rob_d[s];
        pc_q[s]    <= pc_d[s];
        fu_q[s]    <= fu_d[s];
      end
    end
  end

  assign cdb_valid_0  = valid_q[0];
  assign cdb_result_0 = res_q[0];
  assign cdb_dest_0   = dest_q[0];
  assign cdb_rob_0    = rob_q[0];
  assign cdb_pc_0     = pc_q[0];
  assign cdb_fu_0     = fu_q[0];
  assign cdb_valid_1  = valid_q[1];
  assign cdb_result_1 = res_q[1];
  assign cdb_dest_1   = dest_q[1];
  assign cdb_rob_1    = rob_q[1];
  assign cdb_pc_1     = pc_q[1];
  assign cdb_fu_1     = fu_q[1];
  assign grant_cnt    = grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_complete_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_complete_arbiter
// Purpose  : Self-checking bench for complete_arbiter: directed scenarios
//            followed by random traffic, compared against a priority-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complete_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;

  // FU side: pending request and payload per FU (index = FU number)
  logic        pend  [1:3];
  logic [31:0] pres  [1:3];
  logic [5:0]  pdest [1:3];
  logic [3:0]  prob  [1:3];
  logic [6:0]  ppc   [1:3];

  logic        req_ready_1, req_ready_2, req_ready_3;
  logic        cdb_valid_0, cdb_valid_1;
  logic [31:0] cdb_result_0, cdb_result_1;
  logic [5:0]  cdb_dest_0, cdb_dest_1;
  logic [3:0]  cdb_rob_0, cdb_rob_1;
  logic [6:0]  cdb_pc_0, cdb_pc_1;
  logic [1:0]  cdb_fu_0, cdb_fu_1;
  logic [31:0] grant_cnt;
  logic [15:0] conflict_cnt;

  // Reference model state
  int          mrr;
  logic        mv   [2];
  logic [31:0] mres [2];
  logic [5:0]  mdest[2];
  logic [3:0]  mrob [2];
  logic [6:0]  mpc  [2];
  logic [1:0]  mfu  [2];
  logic [31:0] mgc;
  logic [15:0] mcc;

  int n_assert = 0;
  int n_fail   = 0;

  complete_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_1(pend[1]), .req_result_1(pres[1]), .req_dest_1(pdest[1]),
    .req_rob_1(prob[1]), .req_pc_1(ppc[1]), .req_ready_1(req_ready_1),
    .req_valid_2(pend[2]), .req_result_2(pres[2]), .req_dest_2(pdest[2]),
    .req_rob_2(prob[2]), .req_pc_2(ppc[2]), .req_ready_2(req_ready_2),
    .req_valid_3(pend[3]), .req_result_3(pres[3]), .req_dest_3(pdest[3]),
    .req_rob_3(prob[3]), .req_pc_3(ppc[3]), .req_ready_3(req_ready_3),
    .stall_i(stall_i), .flush_i(flush_i),
    .cdb_valid_0(cdb_valid_0), .cdb_result_0(cdb_result_0), .cdb_dest_0(cdb_dest_0),
    .cdb_rob_0(cdb_rob_0), .cdb_pc_0(cdb_pc_0), .cdb_fu_0(cdb_fu_0),
    .cdb_valid_1(cdb_valid_1), .cdb_result_1(cdb_result_1), .cdb_dest_1(cdb_dest_1),
    .cdb_rob_1(cdb_rob_1), .cdb_pc_1(cdb_pc_1), .cdb_fu_1(cdb_fu_1),
    .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mrr = 0;
    mgc = 32'd0;
    mcc = 16'd0;
    for (int s = 0; s < 2; s++) begin
      mv[s] = 1'b0; mres[s] = '0; mdest[s] = '0; mrob[s] = '0; mpc[s] = '0; mfu[s] = 2'd0;
    end
  endtask

  task automatic load_fu(input int k, input logic [31:0] r, input logic [5:0] d,
                         input logic [3:0] rb, input logic [6:0] pc);
    pend[k] = 1'b1; pres[k] = r; pdest[k] = d; prob[k] = rb; ppc[k] = pc;
  endtask

  // Idle FUs raise a fresh random request with probability pct percent
  task automatic refill(input int pct);
    for (int k = 1; k <= 3; k++) begin
      if (!pend[k] && ($urandom_range(99) < pct)) begin
        load_fu(k, $urandom, 6'($urandom), 4'($urandom), 7'($urandom));
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".v0"},   cdb_valid_0,  mv[0]);
    chk({ph, ".fu0"},  cdb_fu_0,     mfu[0]);
    chk({ph, ".res0"}, cdb_result_0, mres[0]);
    chk({ph, ".dst0"}, cdb_dest_0,   mdest[0]);
    chk({ph, ".rob0"}, cdb_rob_0,    mrob[0]);
    chk({ph, ".pc0"},  cdb_pc_0,     mpc[0]);
    chk({ph, ".v1"},   cdb_valid_1,  mv[1]);
    chk({ph, ".fu1"},  cdb_fu_1,     mfu[1]);
    chk({ph, ".res1"}, cdb_result_1, mres[1]);
    chk({ph, ".dst1"}, cdb_dest_1,   mdest[1]);
    chk({ph, ".rob1"}, cdb_rob_1,    mrob[1]);
    chk({ph, ".pc1"},  cdb_pc_1,     mpc[1]);
    chk({ph, ".gcnt"}, grant_cnt,    mgc);
    chk({ph, ".ccnt"}, conflict_cnt, mcc);
  endtask

  // One clock cycle: apply controls, check readys, clock, update model, check slots
  task automatic cycle(input logic st, input logic fl);
    int   g [2];
    logic xfer, all3;
    stall_i = st;
    flush_i = fl;
    #1;
    g[0] = 0; g[1] = 0;
    for (int i = 0; i < 3; i++) begin
      int f;
      f = ((mrr + i) % 3) + 1;
      if (pend[f]) begin
        if (g[0] == 0) g[0] = f;
        else if (g[1] == 0) g[1] = f;
      end
    end
    xfer = !st && !fl;
    all3 = pend[1] && pend[2] && pend[3];
    chk("ready1", req_ready_1, xfer && (g[0] == 1 || g[1] == 1));
    chk("ready2", req_ready_2, xfer && (g[0] == 2 || g[1] == 2));
    chk("ready3", req_ready_3, xfer && (g[0] == 3 || g[1] == 3));
    @(posedge clk);
    #1;
    if (!xfer) begin
      for (int s = 0; s < 2; s++) begin mv[s] = 1'b0; mfu[s] = 2'd0; end
      if (fl) mrr = 0;
    end else begin
      if (all3 && mcc != 16'hFFFF) mcc = mcc + 16'd1;
      for (int s = 0; s < 2; s++) begin
        if (g[s] != 0) begin
          mv[s] = 1'b1; mfu[s] = 2'(g[s]);
          mres[s] = pres[g[s]]; mdest[s] = pdest[g[s]]; mrob[s] = prob[g[s]]; mpc[s] = ppc[g[s]];
          mgc = mgc + 32'd1;
          mrr = g[s] % 3;
          pend[g[s]] = 1'b0;
        end else begin
          mv[s] = 1'b0; mfu[s] = 2'd0;
        end
      end
    end
    check_outputs("cyc");
  endtask

  initial begin
    for (int k = 1; k <= 3; k++) begin
      pend[k] = 1'b0; pres[k] = '0; pdest[k] = '0; prob[k] = '0; ppc[k] = '0;
    end
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_outputs("reset");
    #1 rst_n = 1'b1;

    // FU1 alone
    load_fu(1, 32'h11, 6'd5, 4'd2, 7'h2A);
    cycle(1'b0, 1'b0);
    chk("solo.fu0", cdb_fu_0, 2'd1);
    chk("solo.res0", cdb_result_0, 32'h11);
    chk("solo.v1", cdb_valid_1, 1'b0);
    chk("solo.gcnt", grant_cnt, 32'd1);

    // Three-way contention from pointer 0
    cycle(1'b0, 1'b1);
    refill(100);
    cycle(1'b0, 1'b0);
    chk("c3a.fu0", cdb_fu_0, 2'd1); chk("c3a.fu1", cdb_fu_1, 2'd2);
    refill(100);
    cycle(1'b0, 1'b0);
    chk("c3b.fu0", cdb_fu_0, 2'd3); chk("c3b.fu1", cdb_fu_1, 2'd1);
    refill(100);
    cycle(1'b0, 1'b0);
    chk("c3c.fu0", cdb_fu_0, 2'd2); chk("c3c.fu1", cdb_fu_1, 2'd3);
    chk("c3.ccnt", conflict_cnt, 16'd3);
    chk("c3.gcnt", grant_cnt, 32'd7);

    // Drain outstanding requests (bounded)
    for (int i = 0; i < 6 && (pend[1] || pend[2] || pend[3]); i++) cycle(1'b0, 1'b0);
    chk("drained", {pend[1], pend[2], pend[3]}, 3'b000);

    // Stall with FU2 and FU3 waiting
    load_fu(2, 32'hA2, 6'd12, 4'd7, 7'h02);
    load_fu(3, 32'hB3, 6'd13, 4'd8, 7'h03);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("stall.v0", cdb_valid_0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("unstall.fu0", cdb_fu_0, 2'd2); chk("unstall.fu1", cdb_fu_1, 2'd3);

    // Flush with pointer at 2 while all three are valid
    load_fu(1, 32'h1, 6'd1, 4'd1, 7'h1);
    load_fu(2, 32'h2, 6'd2, 4'd2, 7'h2);
    cycle(1'b0, 1'b0);
    refill(100);
    cycle(1'b0, 1'b1);
    chk("flush.v0", cdb_valid_0, 1'b0); chk("flush.v1", cdb_valid_1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("postflush.fu0", cdb_fu_0, 2'd1); chk("postflush.fu1", cdb_fu_1, 2'd2);

    // Asynchronous reset mid-cycle with both slots valid; FU3 stays pending
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.ready3", req_ready_3, 1'b0);
    check_outputs("arst");
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    chk("arst.after.fu0", cdb_fu_0, 2'd3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      refill(60);
      cycle($urandom_range(9) == 0, $urandom_range(19) == 0);
    end

    // Saturate the conflict counter
    for (int i = 0; i < 65537; i++) begin
      refill(100);
      cycle(1'b0, 1'b0);
    end
    chk("ccnt.sat", conflict_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
